kb_move_decoder: RTL

//   Sits directly downstream of ps2_rx. Consumes raw PS/2 set-2 scan bytes (rx_done_tick/rx_data),

---
 rtl/kb_move_decoder_pkg.sv | 50 +++++
 rtl/kb_move_decoder_prefix_parser.sv | 83 ++++++++
 rtl/kb_move_decoder.sv | 86 ++++++++
 3 files changed

// File: rtl/kb_move_decoder_pkg.sv
// Shared definitions for the keyboard move decoder: move codes, scan
// constants, parser states, held-bit indices and the move priority function.
package kb_move_decoder_pkg;

  // Registered move codes presented to the game logic
  localparam logic [2:0] MOVE_NONE  = 3'b000;
  localparam logic [2:0] MOVE_UP    = 3'b001;
  localparam logic [2:0] MOVE_DOWN  = 3'b010;
  localparam logic [2:0] MOVE_LEFT  = 3'b011;
  localparam logic [2:0] MOVE_RIGHT = 3'b100;
  localparam logic [2:0] MOVE_FIRE  = 3'b101;

  // PS/2 set-2 prefixes and the scan codes we care about
  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;

  // Bit positions inside the held vector {fire,right,left,down,up}
  localparam logic [2:0] HELD_UP    = 3'd0;
  localparam logic [2:0] HELD_DOWN  = 3'd1;
  localparam logic [2:0] HELD_LEFT  = 3'd2;
  localparam logic [2:0] HELD_RIGHT = 3'd3;
  localparam logic [2:0] HELD_FIRE  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } parser_state_t;

  // Fire wins over movement; among directions up > down > left > right
  function automatic logic [2:0] priority_move(input logic [4:0] h);
    if (h[HELD_FIRE])       return MOVE_FIRE;
    else if (h[HELD_UP])    return MOVE_UP;
    else if (h[HELD_DOWN])  return MOVE_DOWN;
    else if (h[HELD_LEFT])  return MOVE_LEFT;
    else if (h[HELD_RIGHT]) return MOVE_RIGHT;
    return MOVE_NONE;
  endfunction

endpackage

// File: rtl/kb_move_decoder_prefix_parser.sv
// Strips E0/F0 prefixes from the PS/2 byte stream and emits one key event
// per complete make/break sequence. A half-received prefix is abandoned
// after TIMEOUT_CYCLES idle cycles so a lost byte cannot poison the next key.
module ps2_prefix_parser
  import kb_move_decoder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  output logic       key_evt,
  output logic       is_ext,
  output logic       is_break,
  output logic [7:0] code
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  parser_state_t    state, state_next;
  logic [CNT_W-1:0] idle_cnt, idle_cnt_next;

  // State and idle-counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      idle_cnt <= '0;
    end else begin
      state    <= state_next;
      idle_cnt <= idle_cnt_next;
    end
  end

  // Prefix tracking, event decode and timeout; events are combinational so the
  // held register can update on the edge that consumes the final byte
  always_comb begin
    state_next    = state;
    idle_cnt_next = idle_cnt;
    key_evt       = 1'b0;
    is_ext        = 1'b0;
    is_break      = 1'b0;
    code          = rx_data;
    if (rx_done_tick) begin
      idle_cnt_next = '0;
      case (state)
        ST_IDLE: begin
          if (rx_data == SC_E0)      state_next = ST_EXT;
          else if (rx_data == SC_F0) state_next = ST_BRK;
          else                       key_evt    = 1'b1;
        end
        ST_EXT: begin
          if (rx_data == SC_F0) begin
            state_next = ST_EXT_BRK;
          end else begin
            key_evt    = 1'b1;
            is_ext     = 1'b1;
            state_next = ST_IDLE;
          end
        end
        ST_BRK: begin
          key_evt    = 1'b1;
          is_break   = 1'b1;
          state_next = ST_IDLE;
        end
        default: begin
          key_evt    = 1'b1;
          is_ext     = 1'b1;
          is_break   = 1'b1;
          state_next = ST_IDLE;
        end
      endcase
    end else if (state == ST_IDLE) begin
      idle_cnt_next = '0;
    end else if (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
      state_next    = ST_IDLE;
      idle_cnt_next = '0;
    end else begin
      idle_cnt_next = idle_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/kb_move_decoder.sv
// Turns parsed PS/2 key events into held-key state for the five game keys,
// a priority-encoded registered move, a change pulse and a per-frame copy.
module kb_move_decoder
  import kb_move_decoder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter bit ENABLE_WASD    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  input  logic       frame_tick,
  output logic [4:0] held,
  output logic [2:0] move,
  output logic       move_changed,
  output logic [2:0] move_frame
);

  logic       key_evt, is_ext, is_break;
  logic [7:0] code;
  logic       key_hit;
  logic [2:0] key_idx;
  logic [4:0] held_next;
  logic [2:0] move_next;

  ps2_prefix_parser #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_parser (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .key_evt      (key_evt),
    .is_ext       (is_ext),
    .is_break     (is_break),
    .code         (code)
  );

  // Map (extended, code) onto a held-bit index; anything else is not a game key
  always_comb begin
    key_hit = 1'b0;
    key_idx = HELD_UP;
    if (is_ext) begin
      case (code)
        SC_UP:    begin key_hit = 1'b1; key_idx = HELD_UP;    end
        SC_DOWN:  begin key_hit = 1'b1; key_idx = HELD_DOWN;  end
        SC_LEFT:  begin key_hit = 1'b1; key_idx = HELD_LEFT;  end
        SC_RIGHT: begin key_hit = 1'b1; key_idx = HELD_RIGHT; end
        default:  ;
      endcase
    end else begin
      case (code)
        SC_SPACE: begin key_hit = 1'b1; key_idx = HELD_FIRE; end
        SC_W:     begin key_hit = ENABLE_WASD; key_idx = HELD_UP;    end
        SC_S:     begin key_hit = ENABLE_WASD; key_idx = HELD_DOWN;  end
        SC_A:     begin key_hit = ENABLE_WASD; key_idx = HELD_LEFT;  end
        SC_D:     begin key_hit = ENABLE_WASD; key_idx = HELD_RIGHT; end
        default:  ;
      endcase
    end
  end

  // Make sets and break clears the mapped bit; repeats and stray breaks fall out naturally
  always_comb begin
    held_next = held;
    if (key_evt && key_hit) held_next[key_idx] = ~is_break;
    move_next = priority_move(held);
  end

  // Held keys, move, change pulse and frame snapshot; move lags held by one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      held         <= '0;
      move         <= MOVE_NONE;
      move_changed <= 1'b0;
      move_frame   <= MOVE_NONE;
    end else begin
      held         <= held_next;
      move         <= move_next;
      move_changed <= (move_next != move);
      if (frame_tick) move_frame <= move;
    end
  end

endmodule
